// File: rtl/computer_top.sv
// Single-cycle Hack-style computer: 16-bit A/D registers, 15-bit PC,
// fixed 32K x 16 instruction ROM and 16K x 16 data RAM.
module computer_top (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] debug_pc,
    output logic [15:0] debug_inst,
    output logic [15:0] debug_inM
);

    localparam int unsigned RamWords = 16384;

    // All architectural state powers up at zero so the machine runs without reset.
    logic [14:0] pc_q = '0;
    logic [15:0] a_q  = '0;
    logic [15:0] d_q  = '0;
    logic [14:0] pc_d;
    logic [15:0] a_d;
    logic [15:0] d_d;

    logic [15:0] ram [RamWords] = '{default: '0};

    logic [15:0] inst;
    logic [15:0] in_m;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        zr;
    logic        ng;
    logic        jump;
    logic        ram_we;

    // Fixed program image; every address not listed reads as zero.
    function automatic logic [15:0] rom_word(input logic [14:0] addr);
        case (addr)
            15'd1:   return 16'h0002;
            15'd2:   return 16'hEC10;
            15'd3:   return 16'h0003;
            15'd4:   return 16'hE090;
            15'd5:   return 16'h0000;
            15'd6:   return 16'hE308;
            15'd7:   return 16'h0006;
            15'd8:   return 16'hE007;
            default: return 16'h0000;
        endcase
    endfunction

    assign inst = rom_word(pc_q);

    // Addresses with A[14] set fall outside the RAM and read as zero.
    assign in_m = a_q[14] ? 16'h0000 : ram[a_q[13:0]];

    assign debug_pc   = pc_q;
    assign debug_inst = inst;
    assign debug_inM  = in_m;

    // ALU: x is D, y is A or M; zero/negate inputs, add or AND, optional output negate.
    always_comb begin
        alu_x   = d_q;
        alu_y   = inst[12] ? in_m : a_q;
        alu_out = '0;
        if (inst[11]) alu_x = '0;
        if (inst[10]) alu_x = ~alu_x;
        if (inst[9])  alu_y = '0;
        if (inst[8])  alu_y = ~alu_y;
        alu_out = inst[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (inst[6])  alu_out = ~alu_out;
    end

    assign zr = (alu_out == 16'h0000);
    assign ng = alu_out[15];

    // Next-state selection for PC, A and D; jumps target the pre-edge A.
    always_comb begin
        jump   = 1'b0;
        ram_we = 1'b0;
        pc_d   = pc_q + 15'd1;
        a_d    = a_q;
        d_d    = d_q;
        if (!inst[15]) begin
            a_d = {1'b0, inst[14:0]};
        end else begin
            jump   = (inst[2] & ng) | (inst[1] & zr) | (inst[0] & ~ng & ~zr);
            ram_we = inst[3] & ~a_q[14];
            if (jump)    pc_d = a_q[14:0];
            if (inst[5]) a_d  = alu_out;
            if (inst[4]) d_d  = alu_out;
        end
    end

    // Register update; reset clears PC/A/D and suppresses all side effects.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
            a_q  <= '0;
            d_q  <= '0;
        end else begin
            pc_q <= pc_d;
            a_q  <= a_d;
            d_q  <= d_d;
        end
    end

    // Data RAM write at the address held in A before the edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram[a_q[13:0]] <= alu_out;
        end
    end

endmodule

// File: tb/tb_computer_top.sv
// Scoreboard bench for computer_top: an instruction-level reference model
// predicts the visible state after every edge; a monitor compares it.
module tb_computer_top;

    localparam int N = 400;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] debug_pc;
    logic [15:0] debug_inst;
    logic [15:0] debug_inM;

    computer_top dut (
        .clk        (clk),
        .reset      (reset),
        .debug_pc   (debug_pc),
        .debug_inst (debug_inst),
        .debug_inM  (debug_inM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] pc;
        logic [15:0] inst;
        logic [15:0] inm;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_rom [32768];
    logic [15:0] m_ram [16384];
    int unsigned m_pc;
    logic [15:0] m_a;
    logic [15:0] m_d;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] ram_rd(input logic [15:0] addr);
        return addr[14] ? 16'h0000 : m_ram[addr[13:0]];
    endfunction

    task automatic check(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Execute one instruction (or reset) at the machine level.
    task automatic model_edge(input logic rst);
        logic [15:0] ins, x, y, o;
        logic        jmp;
        if (rst) begin
            m_pc = 0; m_a = '0; m_d = '0;
            return;
        end
        ins = m_rom[m_pc];
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = (m_pc + 1) % 32768;
            return;
        end
        x = m_d;
        y = ins[12] ? ram_rd(m_a) : m_a;
        if (ins[11]) x = 16'h0000;
        if (ins[10]) x = ~x;
        if (ins[9])  y = 16'h0000;
        if (ins[8])  y = ~y;
        o = ins[7] ? 16'(x + y) : (x & y);
        if (ins[6])  o = ~o;
        jmp = (ins[2] && o[15]) || (ins[1] && o == 0) || (ins[0] && !o[15] && o != 0);
        if (ins[3] && !m_a[14]) m_ram[m_a[13:0]] = o;
        m_pc = jmp ? int'(m_a[14:0]) : (m_pc + 1) % 32768;
        if (ins[5]) m_a = o;
        if (ins[4]) m_d = o;
    endtask

    // Driver: pick reset for each edge, advance the model, queue the expectation.
    initial begin
        logic rst;
        bit   forced = 0;
        int   hold   = 0;
        for (int i = 0; i < 32768; i++) m_rom[i] = 16'h0000;
        for (int i = 0; i < 16384; i++) m_ram[i] = 16'h0000;
        m_rom[1] = 16'h0002; m_rom[2] = 16'hEC10; m_rom[3] = 16'h0003;
        m_rom[4] = 16'hE090; m_rom[6] = 16'hE308; m_rom[7] = 16'h0006;
        m_rom[8] = 16'hE007;
        m_pc = 0; m_a = '0; m_d = '0;
        for (int k = 1; k <= N; k++) begin
            if (k <= 20) begin
                rst = 1'b0;
            end else if (!forced && m_pc == 7) begin
                rst = 1'b1; forced = 1; hold = 9;
            end else if (hold > 0) begin
                rst = 1'b0; hold--;
            end else begin
                rst = ($urandom_range(0, 15) == 0);
            end
            reset = rst;
            model_edge(rst);
            sb.push_back('{pc: m_pc[14:0], inst: m_rom[m_pc], inm: ram_rd(m_a)});
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
    end

    // Monitor: after each edge pop the expectation and compare, plus fixed checks on the opening sequence.
    initial begin
        exp_t        e;
        logic [15:0] seq [8];
        seq[0] = 16'h0002; seq[1] = 16'hEC10; seq[2] = 16'h0003; seq[3] = 16'hE090;
        seq[4] = 16'h0000; seq[5] = 16'hE308; seq[6] = 16'h0006; seq[7] = 16'hE007;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #4;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_empty edge %0d: got 0 entries expected 1", k);
            end else begin
                e = sb.pop_front();
                check("pc", k, {1'b0, debug_pc}, {1'b0, e.pc});
                check("inst", k, debug_inst, e.inst);
                check("inM", k, debug_inM, e.inm);
            end
            if (k <= 8) begin
                check("boot_pc", k, {1'b0, debug_pc}, 16'(k));
                check("boot_inst", k, debug_inst, seq[k-1]);
            end
            if (k == 7) check("boot_inM", k, debug_inM, 16'h0005);
            if (k == 9) check("loop_pc", k, {1'b0, debug_pc}, 16'h0006);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/computer_top.md
COMPUTER_TOP -- requirements
Module: computer

Interface
REQ-001 SHALL have no parameters; ROM program and memory sizes are fixed.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 debug_pc  output  15  current program counter value (address of instruction being executed).
REQ-005 debug_inst  output  16  instruction word ROM[debug_pc], combinational.
REQ-006 debug_inM  output  16  data-memory read value RAM[A], combinational.

Function
REQ-007 SHALL implement a single-cycle Hack-style machine: 16-bit A register, 16-bit D register, 15-bit PC, 32K x 16 instruction ROM, 16K x 16 data RAM.
REQ-008 ROM SHALL be preloaded, all other words 0x0000:
- addr 0: 0x0000 (@0)
- addr 1: 0x0002 (@2)
- addr 2: 0xEC10 (D=A)
- addr 3: 0x0003 (@3)
- addr 4: 0xE090 (D=D+A)
- addr 5: 0x0000 (@0)
- addr 6: 0xE308 (M=D)
- addr 7: 0x0006 (@6)
- addr 8: 0xE007 (D&A;JMP)
REQ-009 A-instruction (inst[15]=0): A <= {1'b0, inst[14:0]}; no other state change except PC+1.
REQ-010 C-instruction (inst[15]=1): inst[14:13] ignored; a=inst[12]; c1..c6=inst[11:6]; dest A,D,M=inst[5:3]; jump lt,eq,gt=inst[2:0].
REQ-011 ALU y operand SHALL be A when a=0, RAM[A] when a=1; x operand is D.
REQ-012 ALU SHALL apply in order: zx (x=0), nx (x=~x), zy, ny, f (1: x+y mod 2^16, 0: x&y), no (out=~out); flags zr=(out==0), ng=out[15].
REQ-013 dest bits SHALL load A, D and/or write RAM[A] with ALU out at the same rising edge; RAM write uses the A value before that edge.
REQ-014 Jump taken when (lt&ng)|(eq&zr)|(gt&~ng&~zr); taken: PC <= A[14:0] (pre-edge A); otherwise PC <= PC+1, wrapping 0x7FFF->0.
REQ-015 RAM address SHALL be A[13:0] when A[14]=0; A[14]=1 reads return 0x0000 and writes are ignored.
REQ-016 debug_inM SHALL reflect RAM[A] combinationally, including a write completed at the previous edge.
REQ-017 Each instruction SHALL complete in exactly one clock cycle; no stalls.

Reset
REQ-018 When reset=1 at a rising edge: PC, A, D <= 0; no RAM write, no instruction side effects that cycle.
REQ-019 Reset asserted mid-run SHALL take effect at the next edge regardless of current instruction; RAM contents retained.
REQ-020 PC, A, D and all RAM words SHALL power up at 0 so the machine runs correctly without ever asserting reset.

Verification
REQ-021 Power-up, reset held 0, free run: after edges 1..8 debug_pc = 1..8 and debug_inst = 0x0002, 0xEC10, 0x0003, 0xE090, 0x0000, 0xE308, 0x0006, 0xE007.
REQ-022 After edge 7 (M=D executed with A=0, D=5): debug_pc=7, debug_inM=0x0005.
REQ-023 Loop: after edge 9 debug_pc=6, then 7, 8, 6 repeating indefinitely; RAM[0] stays 5.
REQ-024 Assert reset for one edge while debug_pc=7 -> next debug_pc=0, debug_inst=0x0000; release -> sequence of REQ-021 repeats.
REQ-025 ALU directed check: D=5, A=3 with D=D+A yields D=8; D=A with A=2 yields D=2; D&A;JMP with A=6 jumps to 6 irrespective of flags.
